// File: rtl/ped_pkg.sv
// ped_pkg
//   Shared types and helpers for the pedestrian crossing signal controller.
//   - ped_state_e : controller states
//   - WALK_SEC_D  : default number of steady WALK seconds
//   - FLASH_SEC_D : default number of flashing DON'T WALK seconds
//   - onehot3()   : true when exactly one of the three street lamps is lit
package ped_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WALK  = 3'd2,
    FLASH = 3'd3,
    CLEAR = 3'd4,
    FAULT = 3'd5
  } ped_state_e;

  localparam int WALK_SEC_D  = 7;
  localparam int FLASH_SEC_D = 8;

  // A healthy traffic light always shows exactly one lamp per street.
  function automatic logic onehot3(input logic r, input logic y, input logic g);
    logic [2:0] lamps;
    lamps = {r, y, g};
    return (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync
//   Brings the asynchronous pedestrian pushbutton into the clk domain and
//   turns each press into a single-cycle pulse.
//   Ports:
//     clk     in  system clock, rising edge
//     reset_n in  synchronous active-low reset
//     btn     in  raw pushbutton, asynchronous, active high
//     press   out one-cycle pulse on each synchronized rising edge of btn
module btn_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Two metastability flops, then one more flop so the synchronized level
  // can be compared against its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Holding the button down produces only one pulse.
  assign press = sync2 & ~sync3;

endmodule

// File: rtl/ped_signal.sv
// ped_signal
//   Pedestrian crossing controller for the crosswalk across street 1.
//   WALK is granted only at the start of a fresh street-1 red phase, then
//   the signal flashes DON'T WALK while a seconds countdown runs to zero.
//   One clock cycle is one second.
//   Ports:
//     clk       in  1 Hz system clock, rising edge
//     reset_n   in  synchronous active-low reset
//     btn       in  raw pedestrian pushbutton (asynchronous)
//     r1,y1,g1  in  street-1 lamps from the traffic light controller
//     walk      out WALK lamp
//     dont_walk out DON'T WALK lamp (steady or flashing)
//     countdown out seconds remaining in the crossing, 0 otherwise
//     ped_req   out request pending toward the traffic light controller
//     short_red out sticky flag: a red phase ended before the crossing did
module ped_signal
  import ped_pkg::*;
#(
  parameter int WALK_SEC  = WALK_SEC_D,
  parameter int FLASH_SEC = FLASH_SEC_D,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn,
  input  logic             r1,
  input  logic             y1,
  input  logic             g1,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             ped_req,
  output logic             short_red
);

  // Countdown shown on the first WALK cycle, and the value shown on the
  // last WALK cycle (the one after which flashing starts).
  localparam logic [CNT_W-1:0] CNT_LOAD      = CNT_W'(WALK_SEC + FLASH_SEC);
  localparam logic [CNT_W-1:0] CNT_LAST_WALK = CNT_W'(FLASH_SEC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  ped_state_e       state;
  ped_state_e       state_nx;
  ped_state_e       back_state;
  logic             press;
  logic             pending;
  logic             pending_nx;
  logic             r1_q;
  logic             red_rise;
  logic             fault;
  logic             walk_nx;
  logic             dont_walk_nx;
  logic [CNT_W-1:0] countdown_nx;
  logic             ped_req_nx;
  logic             short_red_nx;

  btn_sync u_btn_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn),
    .press   (press)
  );

  assign red_rise = r1 & ~r1_q;
  assign fault    = ~onehot3(r1, y1, g1);

  // Where the controller goes once a crossing, clear-out or fault is over:
  // a request that arrived meanwhile is still honoured.
  assign back_state = pending ? WAIT : IDLE;

  // Next state and next registered outputs. Every output is computed for
  // the state being entered so the lamps change on the same edge as the
  // state. Defaults describe the "not crossing" look: steady DON'T WALK
  // and a blank countdown. Priority is fault, then early red end, then
  // the normal sequence.
  always_comb begin
    state_nx     = state;
    walk_nx      = 1'b0;
    dont_walk_nx = 1'b1;
    countdown_nx = '0;
    short_red_nx = short_red;
    pending_nx   = pending | press;

    if (fault) begin
      state_nx = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            state_nx = WAIT;
          end
        end

        WAIT: begin
          if (red_rise) begin
            state_nx     = WALK;
            walk_nx      = 1'b1;
            dont_walk_nx = 1'b0;
            countdown_nx = CNT_LOAD;
            // The request is served; only a brand-new press re-arms it.
            pending_nx   = press;
          end
        end

        WALK: begin
          if (!r1) begin
            state_nx     = back_state;
            short_red_nx = 1'b1;
          end else if (countdown == CNT_LAST_WALK) begin
            state_nx     = FLASH;
            countdown_nx = countdown - CNT_ONE;
          end else begin
            walk_nx      = 1'b1;
            dont_walk_nx = 1'b0;
            countdown_nx = countdown - CNT_ONE;
          end
        end

        FLASH: begin
          if (!r1) begin
            state_nx     = back_state;
            short_red_nx = 1'b1;
          end else if (countdown == CNT_ONE) begin
            state_nx = CLEAR;
          end else begin
            dont_walk_nx = ~dont_walk;
            countdown_nx = countdown - CNT_ONE;
          end
        end

        CLEAR: begin
          // Hold until red ends so one red phase gives at most one WALK.
          if (!r1) begin
            state_nx = back_state;
          end
        end

        FAULT: begin
          // Lamps are healthy again. Going to WAIT rather than WALK means a
          // red edge seen on this very cycle is not honoured.
          state_nx = back_state;
        end

        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    ped_req_nx = (state_nx == WAIT);
  end

  // State and output registers. r1_q resets high so a red lamp that is
  // already on when reset releases is not mistaken for a new red phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      countdown <= '0;
      ped_req   <= 1'b0;
      short_red <= 1'b0;
      pending   <= 1'b0;
      r1_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      walk      <= walk_nx;
      dont_walk <= dont_walk_nx;
      countdown <= countdown_nx;
      ped_req   <= ped_req_nx;
      short_red <= short_red_nx;
      pending   <= pending_nx;
      r1_q      <= r1;
    end
  end

endmodule

// File: tb/tb_ped_signal.sv
// tb_ped_signal
//   Self-checking bench for ped_signal. Drives traffic-light style lamp
//   sequences and pushbutton presses, and compares every output after
//   every edge against a behavioural model that tracks the crossing as
//   "seconds elapsed since WALK started".
module tb_ped_signal;

  localparam int WS = 7;
  localparam int FS = 8;
  localparam int CW = 5;

  // Model activity codes
  localparam int A_IDLE  = 0;
  localparam int A_WAIT  = 1;
  localparam int A_CROSS = 2;
  localparam int A_CLEAR = 3;
  localparam int A_FAULT = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn = 1'b0;
  logic          r1 = 1'b1;
  logic          y1 = 1'b0;
  logic          g1 = 1'b0;
  logic          walk;
  logic          dont_walk;
  logic [CW-1:0] countdown;
  logic          ped_req;
  logic          short_red;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_act;
  int m_t;
  bit m_pending;
  bit m_short;
  bit m_r1_prev;
  bit m_h1, m_h2, m_h3;

  ped_signal #(
    .WALK_SEC  (WS),
    .FLASH_SEC (FS),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn       (btn),
    .r1        (r1),
    .y1        (y1),
    .g1        (g1),
    .walk      (walk),
    .dont_walk (dont_walk),
    .countdown (countdown),
    .ped_req   (ped_req),
    .short_red (short_red)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got=%0d want=%0d", tag, $time, got, want);
    end
  endtask

  // Advance the model by one clock edge with the inputs sampled there.
  // A press is seen by the controller two edges after btn is first
  // sampled high (two synchronizer flops plus the edge detector).
  task automatic modelEdge(input bit rn, input bit b, input bit r, input bit y, input bit g);
    bit press, lamp_fault, rise, served;
    int lit;
    if (!rn) begin
      m_act = A_IDLE; m_t = 0; m_pending = 0; m_short = 0; m_r1_prev = 1;
      m_h1 = 0; m_h2 = 0; m_h3 = 0;
      return;
    end
    press      = m_h2 && !m_h3;
    lit        = int'(r) + int'(y) + int'(g);
    lamp_fault = (lit != 1);
    rise       = r && !m_r1_prev;
    served     = 0;
    if (lamp_fault) begin
      m_act = A_FAULT;
    end else if (m_act == A_IDLE) begin
      if (m_pending) m_act = A_WAIT;
    end else if (m_act == A_WAIT) begin
      if (rise) begin m_act = A_CROSS; m_t = 0; served = 1; end
    end else if (m_act == A_CROSS) begin
      if (!r) begin
        m_short = 1;
        m_act = m_pending ? A_WAIT : A_IDLE;
      end else if (m_t == WS + FS - 1) begin
        m_act = A_CLEAR;
      end else begin
        m_t++;
      end
    end else if (m_act == A_CLEAR) begin
      if (!r) m_act = m_pending ? A_WAIT : A_IDLE;
    end else begin
      m_act = m_pending ? A_WAIT : A_IDLE;
    end
    if (served) m_pending = 0;
    if (press)  m_pending = 1;
    m_r1_prev = r;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = b;
  endtask

  // Drive one second of inputs, let the edge happen, then compare every
  // output with what the model says the crosswalk should show.
  task automatic applyStimulus(input bit rn, input bit b, input bit r, input bit y, input bit g);
    int e_walk, e_dw, e_cd;
    reset_n = rn; btn = b; r1 = r; y1 = y; g1 = g;
    @(posedge clk);
    modelEdge(rn, b, r, y, g);
    #1;
    e_walk = (m_act == A_CROSS && m_t < WS) ? 1 : 0;
    if (m_act != A_CROSS) e_dw = 1;
    else if (m_t < WS)    e_dw = 0;
    else                  e_dw = ((m_t - WS) % 2 == 0) ? 1 : 0;
    e_cd = (m_act == A_CROSS) ? (WS + FS - m_t) : 0;
    checkOutput("walk", int'(walk), e_walk);
    checkOutput("dont_walk", int'(dont_walk), e_dw);
    checkOutput("countdown", int'(countdown), e_cd);
    checkOutput("ped_req", int'(ped_req), (m_act == A_WAIT) ? 1 : 0);
    checkOutput("short_red", int'(short_red), int'(m_short));
  endtask

  // Hold one lamp pattern for n seconds; btn is high only at index press_at.
  task automatic hold(input bit r, input bit y, input bit g, input int n, input int press_at);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, (i == press_at), r, y, g);
  endtask

  // Hold a lamp pattern with random presses, occasional lamp faults and
  // occasional resets.
  task automatic holdRand(input bit r, input bit y, input bit g, input int n);
    logic [2:0] pat;
    bit b, rn;
    for (int i = 0; i < n; i++) begin
      b   = ($urandom_range(0, 5) == 0);
      rn  = ($urandom_range(0, 399) != 0);
      pat = {r, y, g};
      if ($urandom_range(0, 49) == 0) begin
        pat = 3'($urandom_range(0, 7));
        if (pat == 3'b100 || pat == 3'b010 || pat == 3'b001) pat = 3'b110;
      end
      applyStimulus(rn, b, pat[2], pat[1], pat[0]);
    end
  endtask

  initial begin
    $display("[TB] ped_signal bench start");

    // Reset for two seconds with red already lit.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_walk", int'(walk), 0);
    checkOutput("rst_dont_walk", int'(dont_walk), 1);
    checkOutput("rst_countdown", int'(countdown), 0);
    checkOutput("rst_ped_req", int'(ped_req), 0);
    hold(1, 0, 0, 5, -1);
    checkOutput("no_press_walk", int'(walk), 0);

    // Press in green, full crossing on the next red.
    hold(0, 0, 1, 6, 0);
    hold(0, 1, 0, 3, -1);
    checkOutput("req_before_red", int'(ped_req), 1);
    hold(1, 0, 0, 1, -1);
    checkOutput("walk_start", int'(walk), 1);
    checkOutput("walk_cd_load", int'(countdown), WS + FS);
    hold(1, 0, 0, 6, -1);
    checkOutput("walk_last_cd", int'(countdown), FS + 1);
    hold(1, 0, 0, 1, -1);
    checkOutput("flash_first_dw", int'(dont_walk), 1);
    checkOutput("flash_first_cd", int'(countdown), FS);
    hold(1, 0, 0, 17, -1);
    checkOutput("clear_cd", int'(countdown), 0);

    // Red phase too short: ten seconds after WALK starts.
    hold(0, 0, 1, 6, 0);
    hold(0, 1, 0, 3, -1);
    hold(1, 0, 0, 10, -1);
    hold(0, 0, 1, 1, -1);
    checkOutput("short_red_set", int'(short_red), 1);
    checkOutput("short_red_walk", int'(walk), 0);
    hold(0, 0, 1, 5, -1);

    // Press during flashing: no second WALK in this red phase.
    hold(0, 1, 0, 3, -1);
    hold(0, 0, 1, 6, 0);
    hold(0, 1, 0, 3, -1);
    hold(1, 0, 0, 20, 9);
    hold(0, 0, 1, 1, -1);
    checkOutput("req_after_red", int'(ped_req), 1);
    hold(0, 0, 1, 5, -1);
    hold(0, 1, 0, 3, -1);
    hold(1, 0, 0, 1, -1);
    checkOutput("rewalk_next_red", int'(walk), 1);
    hold(1, 0, 0, 20, -1);

    // Lamp fault during WALK, then recovery with nothing pending.
    hold(0, 0, 1, 6, 0);
    hold(0, 1, 0, 3, -1);
    hold(1, 0, 0, 3, -1);
    hold(1, 0, 1, 2, -1);
    checkOutput("fault_walk", int'(walk), 0);
    checkOutput("fault_dw", int'(dont_walk), 1);
    hold(1, 0, 0, 5, -1);
    hold(0, 0, 1, 4, -1);

    // Press position relative to the red edge.
    for (int d = 1; d <= 4; d++) begin
      hold(0, 0, 1, 6, -1);
      hold(0, 1, 0, 4, 4 - d);
      hold(1, 0, 0, 20, -1);
    end

    // Reset in the middle of a crossing.
    hold(0, 0, 1, 6, 0);
    hold(0, 1, 0, 3, -1);
    hold(1, 0, 0, 4, -1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_cd", int'(countdown), 0);
    checkOutput("midrst_walk", int'(walk), 0);
    hold(1, 0, 0, 6, -1);

    // Randomised traffic cycles.
    for (int c = 0; c < 40; c++) begin
      holdRand(0, 0, 1, $urandom_range(3, 12));
      holdRand(0, 1, 0, $urandom_range(2, 4));
      holdRand(1, 0, 0, $urandom_range(5, 25));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_signal.md
Name: ped_signal

Overview:
- Pedestrian crossing signal controller, directly downstream of trafficLight.
- Consumes street-1 lamp outputs (r1, y1, g1) and a pedestrian pushbutton; drives WALK / DON'T WALK lamps and a seconds countdown display for the crosswalk across street 1.
- Grants WALK only at the start of a fresh street-1 red phase and raises ped_req toward the traffic controller while a request is pending.
- Runs on the same 1 Hz system clock, so one cycle = one second.

Parameters:
- WALK_SEC, 7, cycles of steady WALK.
- FLASH_SEC, 8, cycles of flashing DON'T WALK after WALK.
- CNT_W, 5, countdown width; must hold WALK_SEC+FLASH_SEC.

Ports:
- clk  in  1  1 Hz system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- btn  in  1  raw pushbutton, asynchronous, active-high.
- r1  in  1  street-1 red lamp, from trafficLight.
- y1  in  1  street-1 yellow lamp, from trafficLight.
- g1  in  1  street-1 green lamp, from trafficLight.
- walk  out  1  WALK lamp.
- dont_walk  out  1  DON'T WALK lamp; steady or flashing.
- countdown  out  CNT_W  seconds remaining; 0 when not crossing.
- ped_req  out  1  request pending, toward trafficLight.
- short_red  out  1  sticky: red phase ended before the crossing completed.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, via reset_n, and is sampled only on the rising edge of clk.
- Reset values: state=IDLE, walk=0, dont_walk=1, countdown=0, ped_req=0, short_red=0, pending=0, sync flops=0, r1_q=1. Setting r1_q=1 suppresses a false red-edge immediately after reset.
- All outputs are registered.
- A reset asserted mid-crossing returns to the reset values on the next edge, with no partial countdown.
- Button path: 2-flop synchronizer, then rising-edge detect. Each press sets pending. A press is registered if btn is high at one or more clk edges.
- Red edge: red_rise = r1 & ~r1_q, where r1_q is r1 registered.
- Lamp fault: the r1/y1/g1 combination is not exactly one-hot.
- IDLE: dont_walk=1. pending set -> WAIT.
- WAIT: ped_req=1, dont_walk=1.
  - red_rise and no fault -> WALK.
  - If r1 is already high on entry to WAIT, keep waiting for the next red phase.
- WALK: walk=1, dont_walk=0.
  - countdown loads WALK_SEC+FLASH_SEC on entry and decrements by 1 each cycle.
  - After WALK_SEC cycles -> FLASH. The last WALK cycle shows FLASH_SEC+1.
  - pending clears on entry to WALK.
- FLASH: walk=0. dont_walk=1 on the first FLASH cycle, then toggles every cycle.
  - countdown runs FLASH_SEC down to 1.
  - After FLASH_SEC cycles -> CLEAR.
- CLEAR: dont_walk=1 steady, countdown=0.
  - Stays until r1=0, so a second WALK cannot occur in the same red phase.
  - Then pending -> WAIT, else -> IDLE.
- Early red end: r1=0 sampled in WALK or FLASH.
  - Next cycle: walk=0, dont_walk=1 steady, countdown=0.
  - short_red set; it clears only on reset.
  - Then -> WAIT if pending, else IDLE.
- Fault: a fault sampled in any state -> FAULT next cycle.
  - FAULT: walk=0, dont_walk=1, countdown=0, ped_req=0.
  - pending is retained and new presses still latch.
  - Exit when lamps are one-hot again: -> WAIT if pending, else IDLE. A red edge on the exit cycle is not honoured.
- Presses during WAIT/WALK/FLASH/CLEAR/FAULT set pending. There is no queue depth; multiple presses = one request.
- Simultaneous events: a press and red_rise in the same cycle while in IDLE does not start WALK; it goes to WAIT and waits for the next red phase.
- Priority: reset > fault > early red end > normal transitions.

Decomposition:
- Package ped_pkg:
  - ped_state_e enum {IDLE, WAIT, WALK, FLASH, CLEAR, FAULT}.
  - Default constants WALK_SEC_D=7, FLASH_SEC_D=8.
  - Function onehot3(r,y,g).
- Sub-module btn_sync: 2-flop synchronizer plus rising-edge pulse, with synchronous active-low reset.
- The FSM and countdown live in ped_signal.

Test Plan (defaults; trafficLight-style stimulus on r1/y1/g1, 1 Hz clk):
- Reset held 2 cycles, with r1=1 at release -> dont_walk=1, walk=0, countdown=0, ped_req=0; no WALK without a press.
- Press in green, red starts at edge N -> ped_req=1 until WALK. walk=1 from N+1 with countdown 15, and 7 cycles of walk at 15..9. Then FLASH with countdown 8..1, dont_walk 1,0,1,0,... Then CLEAR with countdown 0.
- Red lasts only 10 s after WALK start -> at the cycle after r1=0: walk=0, dont_walk=1 steady, countdown=0, short_red=1 (sticky).
- Press during FLASH -> WALK not re-granted in the same red phase. ped_req=1 after r1 falls, and WALK starts on the next red edge.
- r1 and g1 both high for 2 cycles during WALK -> FAULT: dont_walk=1, walk=0. Lamps restored with pending=0 -> IDLE.
- Press 1 cycle before red_rise versus the same cycle as red_rise -> synchronizer latency decides the outcome. The same-cycle press in IDLE defers WALK to the next red phase.
